sha256_msg_pad1: RTL and testbench

Upstream feeder for `sha256_core`. It accepts a message as a byte stream with a valid/ready handshake and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. It then presents the finished 512-bit block to the core with a one-cycle `start` pulse and holds the block stable until the core reports `digest_valid`. The core has no multi-block chaining, so messages longer than 55 bytes are rejected with `len_err`.

---
 rtl/sha256_msg_pad1.sv | 119 +++++++++++
 tb/tb_sha256_msg_pad1.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_pad1.sv
// Byte-stream front end for sha256_core: packs a message into a single 512-bit
// block with 0x80 marker, zero fill and 64-bit bit length, then hands it to the core.
module sha256_msg_pad1 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_valid,
  input  logic [7:0]   msg_byte,
  input  logic         msg_last,
  input  logic         msg_zero,
  output logic         msg_ready,
  output logic [511:0] block_out,
  output logic         start,
  input  logic         digest_valid,
  output logic         busy,
  output logic         len_err
);

  // Single-block limit of the core: 512 - 8 (marker) - 64 (length) bits.
  localparam int MAX_BYTES = 55;

  typedef enum logic [1:0] {ACCUM, DRAIN, ISSUE, WAIT} state_t;

  state_t         state_reg, state_next;
  logic [5:0]     cnt_reg, cnt_next;
  logic [511:0]   block_reg, block_next, block_pad;
  logic           ready_reg, ready_next;
  logic           len_err_reg, len_err_next;

  logic           accept;
  logic           zero_beat;
  logic           over;
  logic           data_wr;
  logic           pad;
  logic           clear;
  logic [5:0]     final_len;

  assign accept    = msg_valid & ready_reg;
  assign zero_beat = msg_last & msg_zero;
  assign over      = accept && (state_reg == ACCUM) && !zero_beat && (cnt_reg == 6'(MAX_BYTES));
  assign data_wr   = accept && (state_reg == ACCUM) && !zero_beat && !over;
  assign pad       = accept && (state_reg == ACCUM) && msg_last && !over;
  assign final_len = zero_beat ? cnt_reg : cnt_reg + 6'd1;
  assign clear     = over || ((state_reg == WAIT) && digest_valid);

  // Per-byte next value: marker wins over stored data, otherwise hold.
  generate
    for (genvar gi = 0; gi <= MAX_BYTES; gi++) begin : g_byte
      assign block_pad[511-8*gi -: 8] =
        (pad && (final_len == 6'(gi)))   ? 8'h80 :
        (data_wr && (cnt_reg == 6'(gi))) ? msg_byte :
                                           block_reg[511-8*gi -: 8];
    end
  endgenerate

  assign block_pad[63:0] = pad ? {55'd0, final_len, 3'd0} : block_reg[63:0];
  assign block_next      = clear ? '0 : block_pad;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear)
      cnt_next = '0;
    else if (data_wr)
      cnt_next = cnt_reg + 6'd1;
  end

  assign len_err_next = over;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ACCUM;
      cnt_reg     <= '0;
      block_reg   <= '0;
      ready_reg   <= 1'b0;
      len_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      block_reg   <= block_next;
      ready_reg   <= ready_next;
      len_err_reg <= len_err_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM: begin
        if (over)
          state_next = msg_last ? ACCUM : DRAIN;
        else if (pad)
          state_next = ISSUE;
      end
      DRAIN: begin
        if (accept && msg_last)
          state_next = ACCUM;
      end
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (digest_valid)
          state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // Output logic; ready is registered so it reads 0 while held in reset.
  always_comb begin
    start      = (state_reg == ISSUE);
    busy       = (state_reg == ISSUE) || (state_reg == WAIT);
    ready_next = (state_next == ACCUM) || (state_next == DRAIN);
  end

  assign msg_ready = ready_reg;
  assign block_out = block_reg;
  assign len_err   = len_err_reg;

endmodule

// File: tb/tb_sha256_msg_pad1.sv
// Directed bench for sha256_msg_pad1; the core is modelled by a digest_valid
// pulse 10 cycles after start.
module tb_sha256_msg_pad1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         msg_valid = 1'b0;
  logic [7:0]   msg_byte = 8'h00;
  logic         msg_last = 1'b0;
  logic         msg_zero = 1'b0;
  logic         msg_ready;
  logic [511:0] block_out;
  logic         start;
  logic         digest_valid = 1'b0;
  logic         busy;
  logic         len_err;

  sha256_msg_pad1 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg_valid    (msg_valid),
    .msg_byte     (msg_byte),
    .msg_last     (msg_last),
    .msg_zero     (msg_zero),
    .msg_ready    (msg_ready),
    .block_out    (block_out),
    .start        (start),
    .digest_valid (digest_valid),
    .busy         (busy),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'd0, 64'h18};
  localparam logic [511:0] BLK_EMPTY = {8'h80, 440'd0, 64'h0};
  localparam logic [511:0] BLK_A55   = {{55{8'h41}}, 8'h80, 64'h1B8};

  int   n_checks = 0;
  int   n_fail = 0;
  int   start_cnt = 0;
  int   len_err_cnt = 0;
  int   overlap_cnt = 0;
  int   restart_cnt = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (start) start_cnt++;
    if (len_err) len_err_cnt++;
    if (start && len_err) overlap_cnt++;
    if (start && busy_prev) restart_cnt++;
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] b, input logic last, input logic zero);
    int guard;
    guard = 0;
    msg_valid = 1'b1;
    msg_byte  = b;
    msg_last  = last;
    msg_zero  = zero;
    while (!msg_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!msg_ready) check("ready_timeout", msg_ready, 1);
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_zero  = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] b, input logic last_on_end);
    for (int i = 0; i < n; i++)
      send_beat(b, last_on_end && (i == n - 1), 1'b0);
  endtask

  task automatic send_abc();
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
  endtask

  // Called just after the final beat is accepted: checks the issue cycle, the
  // hold through WAIT (optionally with msg_valid asserted), then releases it.
  task automatic core_cycle(input string tag, input logic [511:0] exp, input logic hold_valid);
    logic stable;
    stable = 1'b1;
    if (hold_valid) begin
      msg_valid = 1'b1;
      msg_byte  = 8'hEE;
      msg_last  = 1'b1;
    end
    @(negedge clk);
    check({tag, "_start"}, start, 1);
    check({tag, "_block"}, block_out, exp);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready_issue"}, msg_ready, 0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) digest_valid = 1'b1;
      @(negedge clk);
      if (block_out !== exp || msg_ready !== 1'b0 || start !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
    end
    check({tag, "_hold"}, stable, 1);
    @(posedge clk);
    #1;
    digest_valid = 1'b0;
    msg_valid    = 1'b0;
    msg_last     = 1'b0;
    check({tag, "_cleared"}, block_out, 0);
    check({tag, "_ready_after"}, msg_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  int s0, e0;

  initial begin
    // Reset values
    @(negedge clk);
    check("rst_ready", msg_ready, 0);
    check("rst_block", block_out, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_len_err", len_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", msg_ready, 1);

    // "abc"
    s0 = start_cnt;
    send_abc();
    core_cycle("abc", BLK_ABC, 1'b0);
    check("abc_one_start", start_cnt - s0, 1);

    // Empty message
    send_beat(8'hFF, 1'b1, 1'b1);
    core_cycle("empty", BLK_EMPTY, 1'b0);

    // 55 bytes, last on the 55th
    s0 = start_cnt;
    send_bytes(55, 8'h41, 1'b1);
    core_cycle("a55", BLK_A55, 1'b0);
    check("a55_one_start", start_cnt - s0, 1);

    // 55 bytes, then a zero-length last beat
    send_bytes(55, 8'h41, 1'b0);
    send_beat(8'h99, 1'b1, 1'b1);
    core_cycle("a55z", BLK_A55, 1'b0);

    // 56 bytes, last on the 56th
    s0 = start_cnt;
    e0 = len_err_cnt;
    send_bytes(55, 8'h41, 1'b0);
    send_beat(8'h42, 1'b1, 1'b0);
    @(negedge clk);
    check("b56_len_err", len_err, 1);
    check("b56_ready", msg_ready, 1);
    @(negedge clk);
    check("b56_len_err_drop", len_err, 0);
    check("b56_no_start", start_cnt - s0, 0);
    check("b56_one_err", len_err_cnt - e0, 1);
    send_abc();
    core_cycle("abc_after56", BLK_ABC, 1'b1);

    // 60 bytes, last on the 60th
    s0 = start_cnt;
    e0 = len_err_cnt;
    send_bytes(55, 8'h41, 1'b0);
    send_beat(8'h42, 1'b0, 1'b0);
    @(negedge clk);
    check("b60_len_err", len_err, 1);
    for (int k = 0; k < 4; k++) begin
      check("b60_drain_ready", msg_ready, 1);
      send_beat(8'h43, k == 3, 1'b0);
    end
    @(negedge clk);
    check("b60_ready_end", msg_ready, 1);
    check("b60_no_start", start_cnt - s0, 0);
    check("b60_one_err", len_err_cnt - e0, 1);
    send_abc();
    core_cycle("abc_after60", BLK_ABC, 1'b0);

    // Reset mid-message
    s0 = start_cnt;
    e0 = len_err_cnt;
    send_bytes(3, 8'h55, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_block", block_out, 0);
    check("midrst_ready", msg_ready, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_abc();
    core_cycle("abc_after_rst", BLK_ABC, 1'b0);
    check("midrst_one_start", start_cnt - s0, 1);
    check("midrst_no_err", len_err_cnt - e0, 0);

    check("start_len_err_overlap", overlap_cnt, 0);
    check("start_while_busy", restart_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
